// File: rtl/agc_counter_arbiter.sv
// agc_counter_arbiter
// Counter-cell priority arbiter and sequencer. Holds plus/minus increment
// requests from the involuntary counter cells as pending bits and, at each
// memory-cycle boundary, steals one counter cycle for the highest-priority
// pending cell (cell 0 highest).
//
// Ports
//   CLOCK     in   system clock, rising edge
//   SIM_RST   in   synchronous active-high reset
//   REQ_P     in   per-cell plus-increment request pulse
//   REQ_M     in   per-cell minus-increment request pulse
//   MCT_END   in   end-of-memory-cycle pulse
//   INKL      in   inhibit starting counter cycles
//   CTR_BUSY  out  counter cycle in progress
//   CTR_ADDR  out  erasable address of serviced cell, 0 when idle
//   CTR_OP    out  00 none, 01 PINC, 10 MINC
//   CTR_DONE  out  one-clock pulse after a counter cycle
//   CTR_PEND  out  OR of all pending bits
//   REQ_LOST  out  one-clock pulse when a duplicate request is dropped
module agc_counter_arbiter #(
    parameter int unsigned NCTR      = 20,
    parameter logic [11:0] BASE_ADDR = 12'o0024,
    parameter int unsigned CYCLE_LEN = 12
) (
    input  logic            CLOCK,
    input  logic            SIM_RST,
    input  logic [NCTR-1:0] REQ_P,
    input  logic [NCTR-1:0] REQ_M,
    input  logic            MCT_END,
    input  logic            INKL,
    output logic            CTR_BUSY,
    output logic [11:0]     CTR_ADDR,
    output logic [1:0]      CTR_OP,
    output logic            CTR_DONE,
    output logic            CTR_PEND,
    output logic            REQ_LOST
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned SEL_W  = (NCTR > 1) ? $clog2(NCTR) : 1;
    localparam int unsigned CNT_W  = $clog2(CYCLE_LEN + 1);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PINC = 2'b01;
    localparam logic [1:0] OP_MINC = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NCTR-1:0]     pp_q, pp_d;
    logic [NCTR-1:0]     pm_q, pm_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [1:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          ctr_op_q, ctr_op_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic                lost_q, lost_d;

    logic                last_run_c;
    logic [NCTR-1:0]     svc_c;
    logic [NCTR-1:0]     cand_c;
    logic [SEL_W-1:0]    pick_c;
    logic                found_c;

    // Final clock of the counter cycle; the serviced bit clears at its end.
    assign last_run_c = (state_q == S_RUN) && (cnt_q == CNT_W'(CYCLE_LEN - 1));
    assign svc_c      = last_run_c ? (NCTR'(1) << sel_q) : '0;

    // Request capture. The service clear is applied after capture, but a
    // lone same-sign request on the final clock re-arms the bit and is not
    // counted as a duplicate.
    always_comb begin
        pp_d   = pp_q;
        pm_d   = pm_q;
        lost_d = 1'b0;
        for (int unsigned i = 0; i < NCTR; i++) begin
            if (REQ_P[i] && !REQ_M[i]) begin
                if (pm_q[i]) begin
                    pp_d[i] = 1'b0;
                    pm_d[i] = 1'b0;
                end else if (pp_q[i]) begin
                    if (!(svc_c[i] && (op_q == OP_PINC))) begin
                        lost_d = 1'b1;
                    end
                end else begin
                    pp_d[i] = 1'b1;
                end
            end else if (REQ_M[i] && !REQ_P[i]) begin
                if (pp_q[i]) begin
                    pp_d[i] = 1'b0;
                    pm_d[i] = 1'b0;
                end else if (pm_q[i]) begin
                    if (!(svc_c[i] && (op_q == OP_MINC))) begin
                        lost_d = 1'b1;
                    end
                end else begin
                    pm_d[i] = 1'b1;
                end
            end
            if (svc_c[i]) begin
                if ((op_q == OP_PINC) && !(REQ_P[i] && !REQ_M[i])) begin
                    pp_d[i] = 1'b0;
                end
                if ((op_q == OP_MINC) && !(REQ_M[i] && !REQ_P[i])) begin
                    pm_d[i] = 1'b0;
                end
            end
        end
    end

    assign pend_d = |(pp_d | pm_d);

    // Arbitration candidates: cells pending now that survive this clock's capture.
    always_comb begin
        cand_c  = (pp_q | pm_q) & (pp_d | pm_d);
        found_c = 1'b0;
        pick_c  = '0;
        for (int i = int'(NCTR) - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                found_c = 1'b1;
                pick_c  = SEL_W'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (MCT_END && pend_q && !INKL) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (found_c) begin
                    sel_d   = pick_c;
                    op_d    = pp_d[pick_c] ? OP_PINC : OP_MINC;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_run_c) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d == S_RUN);
        addr_d   = busy_d ? (BASE_ADDR + ADDR_W'(sel_d)) : '0;
        ctr_op_d = busy_d ? op_d : OP_NONE;
        done_d   = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state_q  <= S_IDLE;
            pp_q     <= '0;
            pm_q     <= '0;
            sel_q    <= '0;
            op_q     <= OP_NONE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            ctr_op_q <= OP_NONE;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pp_q     <= pp_d;
            pm_q     <= pm_d;
            sel_q    <= sel_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            ctr_op_q <= ctr_op_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            lost_q   <= lost_d;
        end
    end

    assign CTR_BUSY = busy_q;
    assign CTR_ADDR = addr_q;
    assign CTR_OP   = ctr_op_q;
    assign CTR_DONE = done_q;
    assign CTR_PEND = pend_q;
    assign REQ_LOST = lost_q;

endmodule

// File: tb/tb_agc_counter_arbiter.sv
// Testbench for agc_counter_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of pending requests and the counter-cycle timeline.
module tb_agc_counter_arbiter;

    localparam int unsigned NCTR      = 20;
    localparam int unsigned CYCLE_LEN = 12;
    localparam logic [11:0] BASE      = 12'o0024;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCTR-1:0] rp;
    logic [NCTR-1:0] rm;
    logic            mct;
    logic            inkl;
    logic            busy;
    logic [11:0]     addr;
    logic [1:0]      op;
    logic            done;
    logic            pend;
    logic            lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    agc_counter_arbiter #(
        .NCTR      (NCTR),
        .BASE_ADDR (BASE),
        .CYCLE_LEN (CYCLE_LEN)
    ) dut (
        .CLOCK    (clk),
        .SIM_RST  (rst),
        .REQ_P    (rp),
        .REQ_M    (rm),
        .MCT_END  (mct),
        .INKL     (inkl),
        .CTR_BUSY (busy),
        .CTR_ADDR (addr),
        .CTR_OP   (op),
        .CTR_DONE (done),
        .CTR_PEND (pend),
        .REQ_LOST (lost)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pending per cell: +1 plus, -1 minus, 0 none
    int m_pend [NCTR];
    int m_newp [NCTR];
    bit m_arb, m_done, m_lost, m_valid;
    int m_left;          // RUN clocks remaining
    int m_sel, m_op;     // m_op: +1 PINC, -1 MINC

    initial begin
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCTR); i++) m_pend[i] = 0;
            m_arb = 0; m_done = 0; m_left = 0; m_sel = 0; m_op = 0; m_lost = 0;
            m_valid = 1'b1;
        end else begin
            bit fin;
            bit any_old;
            bit lst;
            int pick;
            fin = (m_left == 1);
            any_old = 0;
            lst = 0;
            for (int i = 0; i < int'(NCTR); i++) begin
                int sgn;
                bit svc;
                if (m_pend[i] != 0) any_old = 1;
                sgn = (rp[i] && !rm[i]) ? 1 : ((rm[i] && !rp[i]) ? -1 : 0);
                svc = fin && (i == m_sel);
                m_newp[i] = m_pend[i];
                if (sgn != 0) begin
                    if (m_pend[i] == -sgn) m_newp[i] = 0;
                    else if (m_pend[i] == sgn) begin
                        if (!(svc && sgn == m_op)) lst = 1;
                    end else m_newp[i] = sgn;
                end
                if (svc && sgn != m_op && m_newp[i] == m_op) m_newp[i] = 0;
            end
            if (m_done) m_done = 0;
            else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (m_arb) begin
                m_arb = 0;
                pick = -1;
                for (int i = int'(NCTR) - 1; i >= 0; i--)
                    if (m_pend[i] != 0 && m_newp[i] != 0) pick = i;
                if (pick >= 0) begin
                    m_sel = pick;
                    m_op = m_newp[pick];
                    m_left = int'(CYCLE_LEN);
                end
            end else if (mct && any_old && !inkl) begin
                m_arb = 1;
            end
            for (int i = 0; i < int'(NCTR); i++) m_pend[i] = m_newp[i];
            m_lost = lst;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            bit eb;
            bit ep;
            eb = (m_left > 0);
            ep = 0;
            for (int i = 0; i < int'(NCTR); i++) if (m_pend[i] != 0) ep = 1;
            chk("model_busy", 32'(busy), 32'(eb));
            chk("model_addr", 32'(addr), eb ? 32'(BASE + 12'(m_sel)) : 32'd0);
            chk("model_op",   32'(op),   eb ? ((m_op > 0) ? 32'd1 : 32'd2) : 32'd0);
            chk("model_done", 32'(done), 32'(m_done));
            chk("model_pend", 32'(pend), 32'(ep));
            chk("model_lost", 32'(lost), 32'(m_lost));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [NCTR-1:0] oh(input int i);
        logic [NCTR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic cyc(input logic [NCTR-1:0] p, input logic [NCTR-1:0] m,
                       input logic mc, input logic r);
        rp  = p;
        rm  = m;
        mct = mc;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rp = '0; rm = '0; mct = 1'b0; inkl = 1'b0;

        // Reset with all plus requests asserted
        repeat (3) cyc('1, '0, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_op",   32'(op),   32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        idle(1);
        chk("rst_pend", 32'(pend), 32'd0);

        // Single PINC on cell 5
        cyc(oh(5), '0, 1'b0, 1'b0);
        chk("pinc_pend", 32'(pend), 32'd1);
        cyc('0, '0, 1'b1, 1'b0);
        chk("pinc_arb_busy", 32'(busy), 32'd0);
        idle(1);
        chk("pinc_busy1", 32'(busy), 32'd1);
        chk("pinc_addr",  32'(addr), 32'(12'o0031));
        chk("pinc_op",    32'(op),   32'd1);
        idle(11);
        chk("pinc_busy12", 32'(busy), 32'd1);
        chk("pinc_pend12", 32'(pend), 32'd1);
        idle(1);
        chk("pinc_done",  32'(done), 32'd1);
        chk("pinc_busy_off", 32'(busy), 32'd0);
        chk("pinc_pend_off", 32'(pend), 32'd0);
        idle(1);
        chk("pinc_done_off", 32'(done), 32'd0);

        // Priority: cell 2 plus beats cell 7 minus
        cyc(oh(2), oh(7), 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("prio1_addr", 32'(addr), 32'(12'o0026));
        chk("prio1_op",   32'(op),   32'd1);
        idle(13);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("prio2_addr", 32'(addr), 32'(12'o0033));
        chk("prio2_op",   32'(op),   32'd2);
        idle(13);

        // Cancel, then duplicate
        cyc(oh(3), '0, 1'b0, 1'b0);
        cyc('0, oh(3), 1'b0, 1'b0);
        chk("cancel_pend", 32'(pend), 32'd0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("cancel_busy", 32'(busy), 32'd0);
        cyc(oh(4), '0, 1'b0, 1'b0);
        cyc(oh(4), '0, 1'b0, 1'b0);
        chk("dup_lost", 32'(lost), 32'd1);
        idle(1);
        chk("dup_lost_off", 32'(lost), 32'd0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("dup_addr", 32'(addr), 32'(12'o0030));
        idle(12);
        chk("dup_done", 32'(done), 32'd1);
        chk("dup_pend", 32'(pend), 32'd0);
        idle(1);

        // Inhibit
        cyc(oh(0), '0, 1'b0, 1'b0);
        inkl = 1'b1;
        cyc('0, '0, 1'b1, 1'b0);
        idle(3);
        chk("inkl_busy", 32'(busy), 32'd0);
        chk("inkl_pend", 32'(pend), 32'd1);
        inkl = 1'b0;
        idle(1);
        chk("inkl_noremember", 32'(busy), 32'd0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("inkl_addr", 32'(addr), 32'(12'o0024));
        idle(13);

        // Reset during RUN clock 6
        cyc(oh(9), '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(6);
        chk("mid_busy6", 32'(busy), 32'd1);
        cyc('0, '0, 1'b0, 1'b1);
        chk("mid_busy_off", 32'(busy), 32'd0);
        chk("mid_pend",     32'(pend), 32'd0);
        idle(1);
        chk("mid_nodone",   32'(done), 32'd0);
        cyc(oh(9), '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle(1);
        chk("mid_re_addr", 32'(addr), 32'(12'o0035));
        idle(13);

        // Randomized traffic; second half concentrates on a few cells
        for (int n = 0; n < 4000; n++) begin
            logic [NCTR-1:0] p;
            logic [NCTR-1:0] m;
            int span;
            p = '0;
            m = '0;
            span = (n < 2000) ? int'(NCTR) : 3;
            for (int i = 0; i < span; i++) begin
                if ($urandom_range(0, 15) == 0) p[i] = 1'b1;
                if ($urandom_range(0, 15) == 0) m[i] = 1'b1;
            end
            if ($urandom_range(0, 40) == 0) inkl = ~inkl;
            cyc(p, m, ($urandom_range(0, 5) == 0), ($urandom_range(0, 600) == 0));
        end
        inkl = 1'b0;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
